// File: rtl/kairo_mon_pkg.sv
// Shared types and register indices for the kairo run monitor.
package kairo_mon_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  localparam logic [3:0] REG_STATUS = 4'd0;
  localparam logic [3:0] REG_CYCLE  = 4'd1;
  localparam logic [3:0] REG_DDATA  = 4'd2;
  localparam logic [3:0] REG_NEVT   = 4'd3;
  localparam logic [3:0] REG_EVT0   = 4'd4;
endpackage

// File: rtl/kairo_sat_counter.sv
// Clearable up-counter that sticks at all ones instead of wrapping.
module kairo_sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          q <= '0;
    else if (clr)                     q <= '0;
    else if (en && inc && (q != '1))  q <= q + 1'b1;
  end
endmodule

// File: rtl/kairo_run_monitor.sv
// Run monitor: cycle/event counters, completion-write detect, watchdog and
// a one-cycle-latency register read port.
module kairo_run_monitor
  import kairo_mon_pkg::*;
#(
  parameter int          NUM_EVT         = 4,
  parameter int          CNT_W           = 32,
  parameter int unsigned WDOG_CYCLES     = 100000,
  parameter logic [31:0] COMPLETION_ADDR = 32'h0000_FFFC
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [NUM_EVT-1:0] EVT,
  input  logic               D_MEM_VALID,
  input  logic               D_MEM_READY,
  input  logic [3:0]         D_MEM_WSTB,
  input  logic [31:0]        D_MEM_ADDR,
  input  logic [31:0]        D_MEM_WDATA,
  input  logic               REG_VALID,
  input  logic [3:0]         REG_ADDR,
  output logic               REG_READY,
  output logic [31:0]        REG_RDATA,
  output logic [1:0]         STATE,
  output logic               DONE,
  output logic               TIMEOUT,
  output logic [31:0]        DONE_DATA
);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
  localparam logic [31:0]      WORD_MASK = ~32'h3;

  mon_state_e                        state_q;
  logic                              done_q, timeout_q;
  logic [31:0]                       ddata_q;
  logic                              rready_q;
  logic [31:0]                       rdata_q, rd_mux;
  logic [CNT_W-1:0]                  cyc_cnt;
  logic [NUM_EVT-1:0][CNT_W-1:0]     evt_cnt;
  logic                              in_run, hit, wdog;

  assign in_run = (state_q == ST_RUN);
  assign hit    = D_MEM_VALID & D_MEM_READY & (|D_MEM_WSTB) &
                  ((D_MEM_ADDR & WORD_MASK) == (COMPLETION_ADDR & WORD_MASK));
  assign wdog   = in_run && (cyc_cnt == WDOG_LAST);

  // START clears via clr, which takes priority over counting in the same cycle
  kairo_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .CLK(CLK), .RST(RST), .clr(START), .en(in_run), .inc(1'b1), .q(cyc_cnt)
  );

  kairo_sat_counter #(.W(CNT_W)) u_evt_cnt [NUM_EVT-1:0] (
    .CLK(CLK), .RST(RST), .clr(START), .en(in_run), .inc(EVT), .q(evt_cnt)
  );

  // A hit beats the watchdog; START beats both
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ddata_q   <= '0;
    end else if (START) begin
      state_q   <= ST_RUN;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (in_run) begin
      if (hit) begin
        state_q <= ST_DONE;
        done_q  <= 1'b1;
        ddata_q <= D_MEM_WDATA;
      end else if (wdog) begin
        state_q   <= ST_TIMEOUT;
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (REG_ADDR)
      REG_STATUS: rd_mux = {28'b0, timeout_q, done_q, state_q};
      REG_CYCLE:  rd_mux = 32'(cyc_cnt);
      REG_DDATA:  rd_mux = ddata_q;
      REG_NEVT:   rd_mux = 32'(NUM_EVT);
      default: begin
        for (int i = 0; i < NUM_EVT; i++)
          if (REG_ADDR == REG_EVT0 + 4'(i)) rd_mux = 32'(evt_cnt[i]);
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rready_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rready_q <= REG_VALID;
      if (REG_VALID) rdata_q <= rd_mux;
    end
  end

  assign REG_READY = rready_q;
  assign REG_RDATA = rdata_q;
  assign STATE     = state_q;
  assign DONE      = done_q;
  assign TIMEOUT   = timeout_q;
  assign DONE_DATA = ddata_q;
endmodule

// File: tb/tb_kairo_run_monitor.sv
// Directed bench: three monitors (default, short watchdog, 16-bit counters)
// share one stimulus stream; each test checks the instance it targets.
module tb_kairo_run_monitor;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [3:0]  EVT = '0;
  logic        D_MEM_VALID = 1'b0, D_MEM_READY = 1'b0;
  logic [3:0]  D_MEM_WSTB = '0;
  logic [31:0] D_MEM_ADDR = '0, D_MEM_WDATA = '0;
  logic        REG_VALID = 1'b0;
  logic [3:0]  REG_ADDR = '0;

  logic        ready_a, ready_b, ready_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic [1:0]  state_a, state_b, state_c;
  logic        done_a, done_b, done_c;
  logic        tmo_a, tmo_b, tmo_c;
  logic [31:0] ddata_a, ddata_b, ddata_c;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  kairo_run_monitor u_dut_a (
    .CLK(CLK), .RST(RST), .START(START), .EVT(EVT),
    .D_MEM_VALID(D_MEM_VALID), .D_MEM_READY(D_MEM_READY), .D_MEM_WSTB(D_MEM_WSTB),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_WDATA(D_MEM_WDATA),
    .REG_VALID(REG_VALID), .REG_ADDR(REG_ADDR), .REG_READY(ready_a), .REG_RDATA(rdata_a),
    .STATE(state_a), .DONE(done_a), .TIMEOUT(tmo_a), .DONE_DATA(ddata_a)
  );

  kairo_run_monitor #(.WDOG_CYCLES(100)) u_dut_b (
    .CLK(CLK), .RST(RST), .START(START), .EVT(EVT),
    .D_MEM_VALID(D_MEM_VALID), .D_MEM_READY(D_MEM_READY), .D_MEM_WSTB(D_MEM_WSTB),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_WDATA(D_MEM_WDATA),
    .REG_VALID(REG_VALID), .REG_ADDR(REG_ADDR), .REG_READY(ready_b), .REG_RDATA(rdata_b),
    .STATE(state_b), .DONE(done_b), .TIMEOUT(tmo_b), .DONE_DATA(ddata_b)
  );

  kairo_run_monitor #(.CNT_W(16), .WDOG_CYCLES(65535)) u_dut_c (
    .CLK(CLK), .RST(RST), .START(START), .EVT(EVT),
    .D_MEM_VALID(D_MEM_VALID), .D_MEM_READY(D_MEM_READY), .D_MEM_WSTB(D_MEM_WSTB),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_WDATA(D_MEM_WDATA),
    .REG_VALID(REG_VALID), .REG_ADDR(REG_ADDR), .REG_READY(ready_c), .REG_RDATA(rdata_c),
    .STATE(state_c), .DONE(done_c), .TIMEOUT(tmo_c), .DONE_DATA(ddata_c)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic r, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d);
    D_MEM_VALID = v; D_MEM_READY = r; D_MEM_WSTB = s; D_MEM_ADDR = a; D_MEM_WDATA = d;
  endtask

  // Leaves the bench in the first RUN cycle (cycle count still 0)
  task automatic start_pulse();
    START = 1'b1;
    step(1);
    START = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] da, output logic [31:0] db,
                    output logic [31:0] dc);
    REG_VALID = 1'b1; REG_ADDR = a;
    step(1);
    REG_VALID = 1'b0;
    da = rdata_a; db = rdata_b; dc = rdata_c;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(3);
    checks++; if (state_a !== 2'd0) begin failures++; $display("FAIL rst_state got=%0h exp=0", state_a); end
    checks++; if ({done_a, tmo_a, ready_a} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {done_a, tmo_a, ready_a}); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", rdata_a); end
    checks++; if (ddata_a !== 32'h0) begin failures++; $display("FAIL rst_ddata got=%0h exp=0", ddata_a); end
    RST = 1'b0;
    step(1);
  endtask

  task automatic test_completion();
    logic [31:0] a, b, c;
    start_pulse();
    step(49);
    set_wr(1, 1, 4'hF, 32'h0000_FFFC, 32'h0000_0001);
    step(1);
    set_wr(0, 0, 4'h0, 32'h0, 32'h0);
    checks++; if (state_a !== 2'd2) begin failures++; $display("FAIL cmpl_state got=%0h exp=2", state_a); end
    checks++; if ({done_a, tmo_a} !== 2'b10) begin failures++; $display("FAIL cmpl_flags got=%b exp=10", {done_a, tmo_a}); end
    checks++; if (ddata_a !== 32'h1) begin failures++; $display("FAIL cmpl_ddata got=%0h exp=1", ddata_a); end
    rd(4'd1, a, b, c);
    checks++; if (a !== 32'd50) begin failures++; $display("FAIL cmpl_cycles got=%0d exp=50", a); end
    rd(4'd0, a, b, c);
    checks++; if (a !== 32'h6) begin failures++; $display("FAIL cmpl_status got=%0h exp=6", a); end
    rd(4'd2, a, b, c);
    checks++; if (a !== 32'h1) begin failures++; $display("FAIL cmpl_reg2 got=%0h exp=1", a); end
  endtask

  // EVT[0] every other cycle, interleaved with writes that must not count as hits
  task automatic test_events();
    logic [31:0] a, b, c;
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      EVT = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      case (i % 4)
        1: set_wr(1, 1, 4'h0, 32'h0000_FFFC, 32'hBAD0_0001);
        2: set_wr(1, 1, 4'hF, 32'h0000_FFF8, 32'hBAD0_0002);
        3: set_wr(1, 0, 4'hF, 32'h0000_FFFC, 32'hBAD0_0003);
        default: set_wr(0, 0, 4'h0, 32'h0, 32'h0);
      endcase
      step(1);
    end
    EVT = 4'b0000;
    checks++; if (state_a !== 2'd1) begin failures++; $display("FAIL evt_nohit_state got=%0h exp=1", state_a); end
    set_wr(1, 1, 4'h1, 32'h0000_FFFF, 32'hDEAD_BEEF);
    step(1);
    set_wr(0, 0, 4'h0, 32'h0, 32'h0);
    checks++; if (ddata_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL evt_ddata got=%0h exp=deadbeef", ddata_a); end
    rd(4'd4, a, b, c);
    checks++; if (a !== 32'd10) begin failures++; $display("FAIL evt_reg4 got=%0d exp=10", a); end
    for (int k = 5; k < 8; k++) begin
      rd(4'(k), a, b, c);
      checks++; if (a !== 32'd0) begin failures++; $display("FAIL evt_reg%0d got=%0d exp=0", k, a); end
    end
    rd(4'd1, a, b, c);
    checks++; if (a !== 32'd21) begin failures++; $display("FAIL evt_cycles got=%0d exp=21", a); end
  endtask

  task automatic test_watchdog();
    logic [31:0] a, b, c;
    start_pulse();
    step(99);
    checks++; if (state_b !== 2'd1) begin failures++; $display("FAIL wdog_early_state got=%0h exp=1", state_b); end
    step(1);
    checks++; if ({state_b, done_b, tmo_b} !== 4'b1101) begin failures++; $display("FAIL wdog_fire got=%b exp=1101", {state_b, done_b, tmo_b}); end
    rd(4'd1, a, b, c);
    checks++; if (b !== 32'd100) begin failures++; $display("FAIL wdog_cycles got=%0d exp=100", b); end
    rd(4'd0, a, b, c);
    checks++; if (b !== 32'hB) begin failures++; $display("FAIL wdog_status got=%0h exp=b", b); end
    set_wr(1, 1, 4'hF, 32'h0000_FFFC, 32'h1234_5678);
    step(1);
    set_wr(0, 0, 4'h0, 32'h0, 32'h0);
    checks++; if ({state_b, tmo_b} !== 3'b111) begin failures++; $display("FAIL wdog_late_hit got=%b exp=111", {state_b, tmo_b}); end
    checks++; if (ddata_b !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wdog_ddata got=%0h exp=deadbeef", ddata_b); end
  endtask

  task automatic test_race_back_to_back();
    logic [31:0] a, b, c;
    start_pulse();
    step(99);
    set_wr(1, 1, 4'hF, 32'h0000_FFFC, 32'h0000_0055);
    step(1);
    set_wr(0, 0, 4'h0, 32'h0, 32'h0);
    checks++; if ({state_b, done_b, tmo_b} !== 4'b1010) begin failures++; $display("FAIL race_wdog_hit got=%b exp=1010", {state_b, done_b, tmo_b}); end
    // START, hit and a read of the cycle counter all in one cycle
    START = 1'b1; REG_VALID = 1'b1; REG_ADDR = 4'd1;
    set_wr(1, 1, 4'hF, 32'h0000_FFFC, 32'h0000_AAAA);
    step(1);
    START = 1'b0;
    set_wr(0, 0, 4'h0, 32'h0, 32'h0);
    checks++; if ({state_b, done_b} !== 3'b010) begin failures++; $display("FAIL race_start_state got=%b exp=010", {state_b, done_b}); end
    checks++; if (ddata_b !== 32'h55) begin failures++; $display("FAIL race_start_ddata got=%0h exp=55", ddata_b); end
    checks++; if (rdata_b !== 32'd100 || ready_b !== 1'b1) begin failures++; $display("FAIL race_preclear got=%0d/%b exp=100/1", rdata_b, ready_b); end
    step(1);
    checks++; if (rdata_b !== 32'd0) begin failures++; $display("FAIL b2b_rd0 got=%0d exp=0", rdata_b); end
    step(1);
    checks++; if (rdata_b !== 32'd1 || ready_b !== 1'b1) begin failures++; $display("FAIL b2b_rd1 got=%0d/%b exp=1/1", rdata_b, ready_b); end
    REG_VALID = 1'b0;
    step(1);
    checks++; if (ready_b !== 1'b0 || rdata_b !== 32'd1) begin failures++; $display("FAIL b2b_hold got=%0d/%b exp=1/0", rdata_b, ready_b); end
  endtask

  task automatic test_regmap();
    logic [31:0] a, b, c;
    rd(4'd3, a, b, c);
    checks++; if (a !== 32'd4) begin failures++; $display("FAIL map_nevt got=%0d exp=4", a); end
    rd(4'd8, a, b, c);
    checks++; if (a !== 32'd0) begin failures++; $display("FAIL map_reg8 got=%0h exp=0", a); end
    rd(4'd15, a, b, c);
    checks++; if (a !== 32'd0) begin failures++; $display("FAIL map_reg15 got=%0h exp=0", a); end
  endtask

  task automatic test_saturate();
    logic [31:0] a, b, c;
    start_pulse();
    EVT = 4'b0010;
    step(70000);
    EVT = 4'b0000;
    checks++; if ({state_c, tmo_c} !== 3'b111) begin failures++; $display("FAIL sat_timeout got=%b exp=111", {state_c, tmo_c}); end
    rd(4'd5, a, b, c);
    checks++; if (c !== 32'h0000_FFFF) begin failures++; $display("FAIL sat_reg5 got=%0h exp=ffff", c); end
    rd(4'd4, a, b, c);
    checks++; if (c !== 32'h0) begin failures++; $display("FAIL sat_reg4 got=%0h exp=0", c); end
    rd(4'd15, a, b, c);
    checks++; if (c !== 32'h0) begin failures++; $display("FAIL sat_reg15 got=%0h exp=0", c); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] a, b, c;
    rd(4'd1, a, b, c);
    #2 RST = 1'b1;
    #1;
    checks++; if ({state_a, done_a, tmo_a, ready_a} !== 5'b0) begin failures++; $display("FAIL mrst_flags got=%b exp=00000", {state_a, done_a, tmo_a, ready_a}); end
    checks++; if (rdata_a !== 32'h0 || ddata_a !== 32'h0) begin failures++; $display("FAIL mrst_data got=%0h/%0h exp=0/0", rdata_a, ddata_a); end
    checks++; if (tmo_c !== 1'b0) begin failures++; $display("FAIL mrst_tmo_c got=%b exp=0", tmo_c); end
    step(1);
    RST = 1'b0;
    step(1);
    rd(4'd1, a, b, c);
    checks++; if (a !== 32'h0) begin failures++; $display("FAIL mrst_cycles got=%0h exp=0", a); end
    rd(4'd0, a, b, c);
    checks++; if (a !== 32'h0) begin failures++; $display("FAIL mrst_status got=%0h exp=0", a); end
  endtask

  initial begin
    test_reset();
    test_completion();
    test_events();
    test_watchdog();
    test_race_back_to_back();
    test_regmap();
    test_saturate();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kairo_run_monitor.md
# kairo_run_monitor

Synthesizable run monitor for kairo_soc. It counts cycles and up to NUM_EVT event strobes per run, such as instruction-fetch handshakes, interrupts and GPIO edges. It detects a software completion write on the data-memory bus and enforces a watchdog timeout. Results are exposed through a simple valid/ready register-read port, so the same completion and CPI measurement works in silicon, FPGA and simulation.

## Interface
Parameters:
- NUM_EVT, 4: number of event channels, 1..8
- CNT_W, 32: counter width, 16..32; reads are zero-extended to 32 bits
- WDOG_CYCLES, 100000: RUN cycles before timeout, 1..2^CNT_W-1
- COMPLETION_ADDR, 32'h0000_FFFC: word address of the completion write; bits [1:0] are ignored

Ports:
- CLK, in, 1: single clock
- RST, in, 1: reset, asynchronous, active-high
- START, in, 1: single-cycle pulse; clears all counters and enters RUN
- EVT, in, NUM_EVT: per-cycle event strobes
- D_MEM_VALID, in, 1: data-memory request valid
- D_MEM_READY, in, 1: data-memory request ready
- D_MEM_WSTB, in, 4: write strobes
- D_MEM_ADDR, in, 32: data-memory byte address
- D_MEM_WDATA, in, 32: write data
- REG_VALID, in, 1: register-read request
- REG_ADDR, in, 4: register word index
- REG_READY, out, 1: read data valid
- REG_RDATA, out, 32: read data
- STATE, out, 2: 0=IDLE, 1=RUN, 2=DONE, 3=TIMEOUT
- DONE, out, 1: high in state DONE
- TIMEOUT, out, 1: high in state TIMEOUT
- DONE_DATA, out, 32: captured completion write data

## Operation
- Reset values: all outputs 0, STATE=IDLE, and all counters 0.
- State transitions:
  - IDLE -> RUN on START.
  - RUN -> DONE on a completion hit.
  - RUN -> TIMEOUT when the watchdog expires.
  - DONE or TIMEOUT -> RUN on START.
  - START while in RUN restarts the run: counters clear and the state stays RUN.
- Completion hit: D_MEM_VALID & D_MEM_READY & |D_MEM_WSTB & (D_MEM_ADDR[31:2]==COMPLETION_ADDR[31:2]). Strobes are not applied; the full WDATA is captured into DONE_DATA.
- In RUN:
  - The cycle counter increments every cycle.
  - Event counter i increments when EVT[i]=1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - The exit cycle (the hit or watchdog cycle) is itself counted.
- In DONE, TIMEOUT and IDLE, counters are frozen and EVT and completion hits are ignored.
- Watchdog fires in the RUN cycle where cycle_cnt==WDOG_CYCLES-1 (the count becomes WDOG_CYCLES).
- Completion hit and watchdog expiry in the same cycle: DONE wins and TIMEOUT stays 0.
- START and a hit in the same cycle: START wins; counters clear and the hit is discarded.
- Register map (REG_ADDR):
  - 0: {28'b0, TIMEOUT, DONE, STATE}
  - 1: cycle counter
  - 2: DONE_DATA
  - 3: NUM_EVT
  - 4+i: event counter i
  - Any other index returns 0.
- RST during RUN returns the block to IDLE immediately and clears the counters.

## Timing
- START is sampled at a CLK edge; STATE=RUN in the next cycle with counts 0. The first RUN cycle is counted, so after N RUN cycles the cycle counter reads N.
- A completion hit in cycle t gives STATE=DONE, DONE=1 and valid DONE_DATA at t+1.
- Register read: REG_VALID in cycle t gives REG_READY=1 with REG_RDATA at t+1, for exactly one cycle.
  - Back-to-back reads are allowed: one per cycle, no stall.
  - REG_RDATA holds its value when REG_READY=0.
- A read in the same cycle as START returns the pre-clear value.
- DONE, TIMEOUT and STATE are registered outputs; there is no combinational path from inputs to outputs.

## Structure
- Package kairo_mon_pkg:
  - state enum (IDLE/RUN/DONE/TIMEOUT)
  - register index constants (REG_STATUS, REG_CYCLE, REG_DDATA, REG_NEVT, REG_EVT0)
- Sub-module kairo_sat_counter: parameter W, with inputs clr, en and inc, and output q; it saturates at all ones. Instantiated NUM_EVT+1 times (cycle counter plus one per event).
- The top level contains the FSM, the completion comparator, the DONE_DATA register and the read mux.

## Test plan
- Reset, START, then a write of 0x0000_0001 to 0xFFFC with WSTB=4'hF after 50 RUN cycles -> DONE=1 next cycle, DONE_DATA=1, reg1=50.
- EVT[0] high on every other RUN cycle for 20 cycles, then a hit -> reg4=10, reg5..7=0.
- WDOG_CYCLES=100 with no hit -> TIMEOUT=1 after exactly 100 RUN cycles, reg1=100, reg0=0x0000_000B; a later hit leaves state unchanged.
- Hit and watchdog in the same cycle -> DONE=1, TIMEOUT=0. START and a hit in the same cycle -> RUN with reg1=0.
- CNT_W=16 with EVT[1] held high for 70000 cycles -> reg5=0xFFFF (saturated, no wrap); read REG_ADDR=15 -> 0.
- RST asserted mid-RUN -> STATE=0 and all outputs 0 without a clock edge; a read after release returns 0.
